ml_stage4_accum: RTL and testbench

- Sequential consumer placed directly downstream of the stage-4 lane multiplier; takes its 10 x 14-bit unsigned product vector.
- Accumulates each lane over FRAMES input vectors with saturation.
- Scans the accumulated lanes serially to find the argmax lane.
- Presents the sums, the max value and its index on a valid/ready output for the AXI-side readout logic.

---
 rtl/ml_stage4_pkg.sv | 20 ++
 rtl/ml_sat_add.sv | 25 ++
 rtl/ml_stage4_accum.sv | 122 ++++++++++++
 tb/tb_ml_stage4_accum.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_stage4_pkg.sv
// ============================================================================
// Module   : ml_stage4_pkg
// Brief    : Shared constants and state encoding for the stage-4 accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ml_stage4_pkg;

    localparam int LANES  = 10;
    localparam int LANE_W = 14;
    localparam int IDX_W  = 4;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ml_sat_add.sv
// ============================================================================
// Module   : ml_sat_add
// Brief    : Unsigned saturating adder, ACC_W accumulator plus LANE_W lane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ml_sat_add #(
    parameter int ACC_W  = 18,
    parameter int LANE_W = 14
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [LANE_W-1:0] i_lane,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W:0] w_sum;

    // One extra bit: the carry-out alone decides saturation.
    assign w_sum = {1'b0, i_acc} + {{(ACC_W + 1 - LANE_W){1'b0}}, i_lane};
    assign o_sum = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/ml_stage4_accum.sv
// ============================================================================
// Module   : ml_stage4_accum
// Brief    : Per-lane saturating accumulation over FRAMES vectors, serial
//            argmax scan, and valid/ready result presentation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ml_stage4_accum #(
    parameter int LANES  = ml_stage4_pkg::LANES,
    parameter int LANE_W = ml_stage4_pkg::LANE_W,
    parameter int ACC_W  = 18,
    parameter int FRAMES = 4
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*ACC_W-1:0]    out_sum,
    output logic [ACC_W-1:0]          out_max,
    output logic [ml_stage4_pkg::IDX_W-1:0] out_idx,
    output logic                      out_valid,
    input  logic                      out_ready
);

    import ml_stage4_pkg::*;

    localparam logic [3:0]       c_last_frame = 4'(FRAMES - 1);
    localparam logic [IDX_W-1:0] c_last_lane  = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] c_commit     = IDX_W'(LANES);

    logic [1:0]                   r_state;
    logic [LANES-1:0][ACC_W-1:0]  r_acc;
    logic [LANES-1:0][ACC_W-1:0]  w_acc_next;
    logic [3:0]                   r_frame_cnt;
    logic [IDX_W-1:0]             r_scan_idx;
    logic [IDX_W-1:0]             r_best_idx;
    logic [ACC_W-1:0]             r_best;
    logic [ACC_W-1:0]             w_scan_val;
    logic                         w_accept;
    logic                         w_take;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_ready & in_valid;
    assign out_sum   = r_acc;

    assign w_scan_val = (r_scan_idx <= c_last_lane) ? r_acc[r_scan_idx] : '0;
    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_take     = (r_scan_idx == '0) || (w_scan_val > r_best);

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            ml_sat_add #(
                .ACC_W  (ACC_W),
                .LANE_W (LANE_W)
            ) u_add (
                .i_acc  (r_acc[k]),
                .i_lane (in_data[k*LANE_W +: LANE_W]),
                .o_sum  (w_acc_next[k])
            );
        end
    endgenerate

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_frame_cnt <= '0;
            r_scan_idx  <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            out_max     <= '0;
            out_idx     <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        if (r_frame_cnt == c_last_frame) begin
                            r_frame_cnt <= '0;
                            r_state     <= ST_SCAN;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 4'd1;
                        end
                    end
                end
                ST_SCAN: begin
                    // One cycle per lane, then a commit cycle that registers the result.
                    if (r_scan_idx == c_commit) begin
                        out_max <= r_best;
                        out_idx <= r_best_idx;
                        r_state <= ST_DONE;
                    end else begin
                        if (w_take) begin
                            r_best     <= w_scan_val;
                            r_best_idx <= r_scan_idx;
                        end
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_acc      <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                        r_scan_idx <= '0;
                        r_state    <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ml_stage4_accum.sv
// ============================================================================
// Module   : tb_ml_stage4_accum
// Brief    : Three DUT configurations against a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ml_stage4_accum;

    logic         clk;
    logic         aresetn;
    logic [139:0] in_data;
    logic         in_valid;
    logic         out_ready;

    logic         ir0, ir1, ir2;
    logic         ov0, ov1, ov2;
    logic [179:0] sum0, sum1;
    logic [169:0] sum2;
    logic [17:0]  max0, max1;
    logic [16:0]  max2;
    logic [3:0]   idx0, idx1, idx2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    ml_stage4_accum #(.ACC_W(18), .FRAMES(4)) u_dut0 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir0), .out_sum(sum0), .out_max(max0),
        .out_idx(idx0), .out_valid(ov0), .out_ready(out_ready));

    ml_stage4_accum #(.ACC_W(18), .FRAMES(1)) u_dut1 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir1), .out_sum(sum1), .out_max(max1),
        .out_idx(idx1), .out_valid(ov1), .out_ready(out_ready));

    ml_stage4_accum #(.ACC_W(17), .FRAMES(16)) u_dut2 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir2), .out_sum(sum2), .out_max(max2),
        .out_idx(idx2), .out_valid(ov2), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fr(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 16;
    endfunction

    function automatic int satmax(input int i);
        return (i == 2) ? 131071 : 262143;
    endfunction

    function automatic logic [63:0] get_sum(input int i, input int k);
        if (i == 0) return 64'(sum0[k*18 +: 18]);
        if (i == 1) return 64'(sum1[k*18 +: 18]);
        return 64'(sum2[k*17 +: 17]);
    endfunction

    function automatic logic [63:0] get_max(input int i);
        return (i == 0) ? 64'(max0) : (i == 1) ? 64'(max1) : 64'(max2);
    endfunction

    function automatic logic [63:0] get_idx(input int i);
        return (i == 0) ? 64'(idx0) : (i == 1) ? 64'(idx1) : 64'(idx2);
    endfunction

    function automatic logic get_rdy(input int i);
        return (i == 0) ? ir0 : (i == 1) ? ir1 : ir2;
    endfunction

    function automatic logic get_vld(input int i);
        return (i == 0) ? ov0 : (i == 1) ? ov1 : ov2;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: phase flags plus a busy countdown from last accept to result.
    int m_sum  [3][10];
    bit m_rdy  [3];
    bit m_vld  [3];
    int m_cnt  [3];
    int m_wait [3];
    int m_max  [3];
    int m_idx  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!aresetn) begin
                for (int k = 0; k < 10; k++) m_sum[i][k] = 0;
                m_rdy[i] = 1; m_vld[i] = 0; m_cnt[i] = 0; m_wait[i] = 0;
                m_max[i] = 0; m_idx[i] = 0;
            end else if (m_rdy[i]) begin
                if (in_valid) begin
                    for (int k = 0; k < 10; k++) begin
                        int s;
                        s = m_sum[i][k] + int'(in_data[k*14 +: 14]);
                        m_sum[i][k] = (s > satmax(i)) ? satmax(i) : s;
                    end
                    m_cnt[i]++;
                    if (m_cnt[i] == fr(i)) begin
                        m_cnt[i] = 0; m_rdy[i] = 0; m_wait[i] = 11;
                    end
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_vld[i] = 1;
                    m_max[i] = m_sum[i][0]; m_idx[i] = 0;
                    for (int k = 1; k < 10; k++)
                        if (m_sum[i][k] > m_max[i]) begin
                            m_max[i] = m_sum[i][k]; m_idx[i] = k;
                        end
                end
            end else if (m_vld[i] && out_ready) begin
                m_vld[i] = 0; m_rdy[i] = 1;
                for (int k = 0; k < 10; k++) m_sum[i][k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("dut%0d in_ready", i), 64'(get_rdy(i)), 64'(m_rdy[i]));
                check($sformatf("dut%0d out_valid", i), 64'(get_vld(i)), 64'(m_vld[i]));
                for (int k = 0; k < 10; k++)
                    check($sformatf("dut%0d sum[%0d]", i, k), get_sum(i, k), 64'(m_sum[i][k]));
                if (m_vld[i]) begin
                    check($sformatf("dut%0d out_max", i), get_max(i), 64'(m_max[i]));
                    check($sformatf("dut%0d out_idx", i), get_idx(i), 64'(m_idx[i]));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); aresetn = 1'b0;
        @(negedge clk); aresetn = 1'b1;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < 10; k++) in_data[k*14 +: 14] = 14'(v);
    endtask

    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (!get_vld(i) && n < 40) begin
            @(negedge clk); n++;
        end
    endtask

    initial begin
        int n;
        aresetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        do_reset();
        chk_en = 1;
        check("reset in_ready", 64'(ir0), 64'd1);
        check("reset out_valid", 64'(ov0), 64'd0);
        check("reset out_max", 64'(max0), 64'd0);
        check("reset out_idx", 64'(idx0), 64'd0);

        // Ramp lanes, latency, then backpressure with in_valid asserted.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) in_data[k*14 +: 14] = 14'(100 * k);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_valid(0, n);
        check("ramp latency", 64'(n), 64'd11);
        check("ramp sum[9]", get_sum(0, 9), 64'd3600);
        check("ramp sum[1]", get_sum(0, 1), 64'd400);
        check("ramp out_max", 64'(max0), 64'd3600);
        check("ramp out_idx", 64'(idx0), 64'd9);
        set_all(5); in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("stall in_ready", 64'(ir0), 64'd0);
            check("stall sum[9]", get_sum(0, 9), 64'd3600);
            check("stall out_idx", 64'(idx0), 64'd9);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("release in_ready", 64'(ir0), 64'd1);
        check("release sum[9]", get_sum(0, 9), 64'd0);

        // FRAMES=1 single vector.
        do_reset();
        set_all(0); in_data[3*14 +: 14] = 14'd500; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(1, n);
        check("single latency", 64'(n), 64'd11);
        check("single sum[3]", get_sum(1, 3), 64'd500);
        check("single out_max", 64'(max1), 64'd500);
        check("single out_idx", 64'(idx1), 64'd3);

        // All-equal lanes: tie resolves to lane 0.
        do_reset();
        set_all(7); in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_valid(0, n);
        check("tie sum[0]", get_sum(0, 0), 64'd28);
        check("tie sum[9]", get_sum(0, 9), 64'd28);
        check("tie out_idx", 64'(idx0), 64'd0);

        // Saturation on the 17-bit, 16-frame instance.
        do_reset();
        set_all(16383); in_valid = 1'b1;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        wait_valid(2, n);
        check("sat sum[0]", get_sum(2, 0), 64'd131071);
        check("sat sum[9]", get_sum(2, 9), 64'd131071);
        check("sat out_max", 64'(max2), 64'd131071);
        check("sat out_idx", 64'(idx2), 64'd0);

        // Gapped input.
        do_reset();
        set_all(1); in_data[5*14 +: 14] = 14'd9;
        for (int j = 0; j < 8; j++) begin
            in_valid = (j % 2 == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_valid(0, n);
        check("gap sum[5]", get_sum(0, 5), 64'd36);
        check("gap sum[0]", get_sum(0, 0), 64'd4);
        check("gap out_idx", 64'(idx0), 64'd5);

        // Reset during scan, then a clean run.
        do_reset();
        set_all(1); in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        check("midscan out_valid", 64'(ov0), 64'd0);
        check("midscan in_ready", 64'(ir0), 64'd1);
        check("midscan sum[0]", get_sum(0, 0), 64'd0);
        aresetn = 1'b1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_valid(0, n);
        check("post sum[0]", get_sum(0, 0), 64'd4);
        check("post sum[9]", get_sum(0, 9), 64'd4);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 4000; j++) begin
            @(negedge clk);
            aresetn   = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 10; k++) in_data[k*14 +: 14] = 14'($urandom_range(0, 16383));
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
